// File: rtl/fp16_pkg.sv
// Shared types and field widths for the FP16 normalize/round stage.
package fp16_pkg;

    localparam int unsigned EXP_W  = 5;
    localparam int unsigned FRAC_W = 10;
    localparam int unsigned MANT_W = FRAC_W + 4;
    localparam int unsigned EXPX_W = EXP_W + 1;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp16_t;

endpackage

// File: rtl/rne_rounder.sv
// Round-to-nearest-even increment of a fraction; carry_o flags overflow into the hidden bit.
module rne_rounder
    import fp16_pkg::*;
(
    input  logic [FRAC_W-1:0] frac_i,
    input  logic              guard_i,
    input  logic              sticky_i,
    output logic [FRAC_W-1:0] frac_o,
    output logic              carry_o
);

    logic inc;

    assign inc = guard_i & (sticky_i | frac_i[0]);
    assign {carry_o, frac_o} = {1'b0, frac_i} + (FRAC_W + 1)'(inc);

endmodule

// File: rtl/fp_normalize_round.sv
// FP16 adder back end: normalizes the raw significand sum, rounds RNE and packs binary16.
module fp_normalize_round
    import fp16_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       result
);

    localparam int unsigned CARRY_B  = MANT_W - 1;
    localparam int unsigned HIDDEN_B = MANT_W - 2;

    state_e              state_q, state_d;
    logic                sign_q, sign_d;
    logic [EXPX_W-1:0]   exp_q, exp_d;
    logic [MANT_W-1:0]   mant_q, mant_d;
    logic                subn_q, subn_d;
    fp16_t               result_q, result_d;
    logic                out_valid_q;

    logic                accept;
    logic                exp_is_max;
    logic [EXPX_W-1:0]   exp_inc;
    logic [EXPX_W-1:0]   exp_rnd;
    logic [FRAC_W-1:0]   frac_rnd;
    logic                rnd_carry;

    // Ready is masked by reset so upstream never sees the stage idle while it is being cleared.
    assign in_ready   = (state_q == ST_IDLE) && !reset;
    assign accept     = in_valid && in_ready;
    assign exp_is_max = (exp_q == EXPX_W'(EXP_MAX));
    assign exp_inc    = exp_q + EXPX_W'(1);
    assign exp_rnd    = exp_q + EXPX_W'(rnd_carry);
    assign out_valid  = out_valid_q;
    assign result     = result_q;

    rne_rounder u_rne_rounder (
        .frac_i   (mant_q[HIDDEN_B-1:2]),
        .guard_i  (mant_q[1]),
        .sticky_i (mant_q[0]),
        .frac_o   (frac_rnd),
        .carry_o  (rnd_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sign_q      <= 1'b0;
            exp_q       <= '0;
            mant_q      <= '0;
            subn_q      <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            exp_q       <= exp_d;
            mant_q      <= mant_d;
            subn_q      <= subn_d;
            result_q    <= result_d;
            out_valid_q <= (state_d == ST_DONE);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_NORM;
            end
            ST_NORM: begin
                if (exp_is_max || (mant_q == '0)) begin
                    state_d = ST_DONE;
                end else if (mant_q[CARRY_B]) begin
                    state_d = (exp_inc == EXPX_W'(EXP_MAX)) ? ST_DONE : ST_ROUND;
                end else if (!mant_q[HIDDEN_B] && (exp_q > EXPX_W'(1))) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_ROUND: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, one normalize step per cycle, rounding and packing.
    always_comb begin
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        subn_d   = subn_q;
        result_d = result_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sign_d = in_sign;
                    exp_d  = {1'b0, in_exp};
                    mant_d = in_mant;
                    subn_d = 1'b0;
                end
            end
            ST_NORM: begin
                if (exp_is_max) begin
                    result_d = '{sign: sign_q, exp: EXP_MAX, frac: mant_q[HIDDEN_B-1:2]};
                end else if (mant_q == '0) begin
                    result_d = '{sign: sign_q, exp: '0, frac: '0};
                end else if (mant_q[CARRY_B]) begin
                    // Shifted-out bit folds into sticky so rounding still sees it.
                    mant_d = {1'b0, mant_q[MANT_W-1:1]} | MANT_W'(mant_q[0]);
                    exp_d  = exp_inc;
                    if (exp_inc == EXPX_W'(EXP_MAX)) begin
                        result_d = '{sign: sign_q, exp: EXP_MAX, frac: '0};
                    end
                end else if (!mant_q[HIDDEN_B]) begin
                    if (exp_q > EXPX_W'(1)) begin
                        mant_d = mant_q << 1;
                        exp_d  = exp_q - EXPX_W'(1);
                    end else begin
                        subn_d = 1'b1;
                    end
                end
            end
            ST_ROUND: begin
                if (subn_q) begin
                    result_d = '{sign: sign_q, exp: EXP_W'(rnd_carry), frac: frac_rnd};
                end else if (exp_rnd >= EXPX_W'(EXP_MAX)) begin
                    result_d = '{sign: sign_q, exp: EXP_MAX, frac: '0};
                end else begin
                    result_d = '{sign: sign_q, exp: exp_rnd[EXP_W-1:0], frac: frac_rnd};
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized and directed bench for fp_normalize_round against an integer reference model.
module tb_fp_normalize_round;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [4:0]  in_exp = 5'd0;
    logic [13:0] in_mant = 14'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_normalize_round dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Reference: plain integer arithmetic following the normalize/round rules.
    function automatic void ref_model(input bit s, input int ein, input int mi,
                                      output logic [15:0] res, output int lat);
        int e = ein;
        int m = mi;
        int sig;
        int shifts = 0;
        bit subn;
        lat = 1;
        if (e == 31) begin
            res = {s, 5'h1F, 10'((m >> 2) % 1024)};
            return;
        end
        if (m == 0) begin
            res = {s, 15'h0};
            return;
        end
        if (m >= 8192) begin
            m = (m >> 1) | (m & 1);
            e = e + 1;
            if (e == 31) begin
                res = {s, 5'h1F, 10'h0};
                return;
            end
        end
        while (m < 4096 && e > 1) begin
            m = (m * 2) % 16384;
            e = e - 1;
            shifts++;
        end
        subn = (m < 4096);
        sig  = m >> 2;
        if (((m >> 1) & 1) == 1 && ((m & 1) == 1 || (sig & 1) == 1)) sig = sig + 1;
        lat = 2 + shifts;
        if (subn) begin
            res = {s, (sig >= 1024) ? 5'd1 : 5'd0, 10'(sig % 1024)};
        end else begin
            if (sig >= 2048) begin
                e = e + 1;
                sig = 1024;
            end
            if (e >= 31) res = {s, 5'h1F, 10'h0};
            else         res = {s, 5'(e), 10'(sig % 1024)};
        end
    endfunction

    // Presents one operand; returns at the negedge following the accept edge.
    task automatic drive_accept(input bit s, input logic [4:0] e, input logic [13:0] m, output bit to);
        int n = 0;
        to = 1'b0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            to = 1'b1;
            return;
        end
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        @(negedge clk);
        in_valid = 1'b0;
        in_sign  = 1'($urandom);
        in_exp   = 5'($urandom);
        in_mant  = 14'($urandom);
    endtask

    task automatic wait_done(output int lat, output bit to);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        to = !out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_outputs got valid=%b result=%h exp valid=0 result=0000", out_valid, result);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
        end
    endtask

    typedef struct {
        bit          s;
        logic [4:0]  e;
        logic [13:0] m;
        logic [15:0] res;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[9];
        logic [15:0] r;
        int lat;
        bit to;
        v[0] = '{0, 5'd15, 14'h2000, 16'h4000, 2};
        v[1] = '{0, 5'd15, 14'h0200, 16'h3000, 5};
        v[2] = '{1, 5'd15, 14'h0000, 16'h8000, 1};
        v[3] = '{0, 5'd30, 14'h2000, 16'h7C00, 1};
        v[4] = '{0, 5'd15, 14'h1006, 16'h3C02, 2};
        v[5] = '{0, 5'd15, 14'h1002, 16'h3C00, 2};
        v[6] = '{0, 5'd15, 14'h1FFE, 16'h4000, 2};
        v[7] = '{0, 5'd1,  14'h0800, 16'h0200, 2};
        v[8] = '{0, 5'd31, 14'h1014, 16'h7C05, 1};
        foreach (v[i]) begin
            drive_accept(v[i].s, v[i].e, v[i].m, to);
            if (!to) wait_done(lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL directed_%0d_timeout got=no out_valid exp=out_valid", i);
                continue;
            end
            r = result;
            checks++;
            if (r !== v[i].res) begin
                errors++;
                $display("FAIL directed_%0d_result got=%h exp=%h", i, r, v[i].res);
            end
            checks++;
            if (lat != v[i].lat) begin
                errors++;
                $display("FAIL directed_%0d_latency got=%0d exp=%0d", i, lat, v[i].lat);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [15:0] exp_res;
        int exp_lat, lat;
        bit to, s;
        logic [4:0] e;
        logic [13:0] m;
        for (int i = 0; i < 300; i++) begin
            s = 1'($urandom);
            e = 5'($urandom_range(31, 1));
            m = 14'($urandom) >> $urandom_range(13, 0);
            ref_model(s, int'(e), int'(m), exp_res, exp_lat);
            drive_accept(s, e, m, to);
            if (!to) wait_done(lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL random_%0d_timeout got=no out_valid exp=out_valid", i);
                continue;
            end
            if (result !== exp_res || lat != exp_lat) begin
                errors++;
                $display("FAIL random_%0d s=%b e=%0d m=%h got=%h/%0d exp=%h/%0d",
                         i, s, e, m, result, lat, exp_res, exp_lat);
            end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_res;
        int exp_lat, lat;
        bit to;
        ref_model(1'b1, 20, 14'h0123, exp_res, exp_lat);
        drive_accept(1'b1, 5'd20, 14'h0123, to);
        if (!to) wait_done(lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL backpressure_timeout got=no out_valid exp=out_valid");
            return;
        end
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp_res) begin
                errors++;
                $display("FAIL backpressure_hold_%0d got=v%b r%b %h exp=v1 r0 %h",
                         k, out_valid, in_ready, result, exp_res);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release got=v%b r%b exp=v0 r1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        bit seen = 1'b0;
        drive_accept(1'b0, 5'd15, 14'h0001, to);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold got=v%b r%b exp=v0 r0", out_valid, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_mid_release got=r%b %h exp=r1 0000", in_ready, result);
        end
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL reset_mid_abandon got=out_valid exp=no output");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
